// File: rtl/decode_pkg.sv
// Shared decode constants for the ID stage: opcodes, alu_op encodings,
// branch funct3 values and the packed control-word layout.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_R      = 2'b10;
    localparam logic [1:0] ALU_OP_I      = 2'b11;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam int CTRL_W          = 8;
    localparam int CTRL_MEM_TO_REG = 7;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    // Field order matches the CTRL_* bit indices above (MSB first).
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/decode_if.sv
// Signal bundle between the decode stage and its surrounding pipeline.
// master = pipeline side (IF/ID, WB, EX/MEM), slave = the decode stage.
interface decode_if #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    // Handshake: if_id_valid qualifies instruction/pc. While pc_enable and
    // if_id_enable are low, IF must hold PC and IF/ID unchanged; the stage
    // re-evaluates the same instruction every cycle until both return high.
    // ID/EX has no back-pressure: idex_valid marks a real instruction on
    // every clock, and a bubble is idex_valid=0 with idex_ctrl=0.
    logic                     if_id_valid;
    logic [31:0]              instruction;
    logic [XLEN-1:0]          pc;

    logic                     wb_we;
    logic [REG_ADDR_W-1:0]    wb_rd;
    logic [XLEN-1:0]          wb_data;

    logic [REG_ADDR_W-1:0]    exmem_rd;
    logic                     exmem_reg_write;
    logic                     exmem_mem_read;
    logic [XLEN-1:0]          exmem_alu_result;

    logic                     pc_enable;
    logic                     if_id_enable;
    logic                     if_flush;
    logic                     branch_taken;
    logic [XLEN-1:0]          branch_target;

    logic                     idex_valid;
    logic [7:0]               idex_ctrl;
    logic [3*REG_ADDR_W-1:0]  idex_regs;
    logic [XLEN-1:0]          idex_imm;
    logic [XLEN-1:0]          idex_a;
    logic [XLEN-1:0]          idex_b;
    logic [9:0]               idex_funct;
    logic                     illegal_instr;
    logic [STALL_CNT_W-1:0]   stall_cycles;

    modport master (
        output if_id_valid, instruction, pc,
        output wb_we, wb_rd, wb_data,
        output exmem_rd, exmem_reg_write, exmem_mem_read, exmem_alu_result,
        input  pc_enable, if_id_enable, if_flush, branch_taken, branch_target,
        input  idex_valid, idex_ctrl, idex_regs, idex_imm, idex_a, idex_b,
        input  idex_funct, illegal_instr, stall_cycles
    );

    modport slave (
        input  if_id_valid, instruction, pc,
        input  wb_we, wb_rd, wb_data,
        input  exmem_rd, exmem_reg_write, exmem_mem_read, exmem_alu_result,
        output pc_enable, if_id_enable, if_flush, branch_taken, branch_target,
        output idex_valid, idex_ctrl, idex_regs, idex_imm, idex_a, idex_b,
        output idex_funct, illegal_instr, stall_cycles
    );

endinterface

// File: rtl/decode_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and
// write-through so a same-cycle WB write is visible to ID reads.
module decode_regfile #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [XLEN-1:0]       wd,
    input  logic [REG_ADDR_W-1:0] ra1,
    output logic [XLEN-1:0]       rd1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [XLEN-1:0]       rd2
);
    localparam int NREGS = 1 << REG_ADDR_W;

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// RISC-V ID stage: decode, register read, hazard stall, beq/bne resolution
// and the ID/EX register. Optional macro: DECODE_BRANCH_BYPASS_EN.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input logic     clock,
    input logic     reset,
    decode_if.slave bus
);
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    assign instr  = bus.instruction;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = REG_ADDR_W'(instr[19:15]);
    assign rs2    = REG_ADDR_W'(instr[24:20]);
    assign rd     = REG_ADDR_W'(instr[11:7]);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    ctrl_t           ctrl;
    logic            legal;
    logic            use_rs2;
    logic            is_branch;
    logic [XLEN-1:0] imm;

    always_comb begin
        ctrl      = '0;
        legal     = 1'b1;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        imm       = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OP_R;
                use_rs2        = 1'b1;
            end
            OP_LOAD: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_OP_ADD;
                imm             = imm_i;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OP_I;
                imm            = imm_i;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OP_ADD;
                use_rs2        = 1'b1;
                imm            = imm_s;
            end
            OP_BRANCH: begin
                if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_OP_BRANCH;
                    use_rs2     = 1'b1;
                    is_branch   = 1'b1;
                    imm         = imm_b;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;

    decode_regfile #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (bus.wb_we),
        .wa    (bus.wb_rd),
        .wd    (bus.wb_data),
        .ra1   (rs1),
        .rd1   (rf_a),
        .ra2   (rs2),
        .rd2   (rf_b)
    );

    // ID/EX register contents
    logic                  idex_valid_q;
    ctrl_t                 idex_ctrl_q;
    logic [REG_ADDR_W-1:0] idex_rs1_q;
    logic [REG_ADDR_W-1:0] idex_rs2_q;
    logic [REG_ADDR_W-1:0] idex_rd_q;
    logic [XLEN-1:0]       idex_imm_q;
    logic [XLEN-1:0]       idex_a_q;
    logic [XLEN-1:0]       idex_b_q;
    logic [9:0]            idex_funct_q;
    logic                  illegal_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // A source register only creates a hazard when it is read and not x0.
    function automatic logic hit(input logic used,
                                 input logic [REG_ADDR_W-1:0] src,
                                 input logic [REG_ADDR_W-1:0] producer);
        return used && (src != '0) && (src == producer);
    endfunction

    logic hz_load_use;
    logic hz_idex_branch;
    logic hz_exmem_load;
    logic hz_exmem_alu;
    logic exmem_alu_a;
    logic exmem_alu_b;

    assign hz_load_use = idex_valid_q && idex_ctrl_q.mem_read &&
                         (hit(legal, rs1, idex_rd_q) || hit(use_rs2, rs2, idex_rd_q));
    assign hz_idex_branch = is_branch && idex_valid_q && idex_ctrl_q.reg_write &&
                            (hit(1'b1, rs1, idex_rd_q) || hit(1'b1, rs2, idex_rd_q));
    assign hz_exmem_load = is_branch && bus.exmem_mem_read &&
                           (hit(1'b1, rs1, bus.exmem_rd) || hit(1'b1, rs2, bus.exmem_rd));
    assign exmem_alu_a = is_branch && bus.exmem_reg_write && !bus.exmem_mem_read &&
                         hit(1'b1, rs1, bus.exmem_rd);
    assign exmem_alu_b = is_branch && bus.exmem_reg_write && !bus.exmem_mem_read &&
                         hit(1'b1, rs2, bus.exmem_rd);

    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;

`ifdef DECODE_BRANCH_BYPASS_EN
    assign cmp_a        = exmem_alu_a ? bus.exmem_alu_result : rf_a;
    assign cmp_b        = exmem_alu_b ? bus.exmem_alu_result : rf_b;
    assign hz_exmem_alu = 1'b0;
`else
    // Without the bypass the branch waits until the EX/MEM value is in WB,
    // where the regfile write-through supplies it.
    assign cmp_a        = rf_a;
    assign cmp_b        = rf_b;
    assign hz_exmem_alu = exmem_alu_a || exmem_alu_b;
    logic unused_exmem_alu_result;
    assign unused_exmem_alu_result = ^bus.exmem_alu_result;
`endif

    logic stall;
    logic issue;
    logic take;

    assign stall = !reset && bus.if_id_valid &&
                   (hz_load_use || hz_idex_branch || hz_exmem_load || hz_exmem_alu);
    assign issue = bus.if_id_valid && !stall;
    assign take  = !reset && issue && is_branch &&
                   ((funct3 == F3_BEQ) ? (cmp_a == cmp_b) : (cmp_a != cmp_b));

    assign bus.pc_enable     = !stall;
    assign bus.if_id_enable  = !stall;
    assign bus.branch_taken  = take;
    assign bus.if_flush      = take;
    assign bus.branch_target = bus.pc + imm;

    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            idex_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_rd_q    <= '0;
            idex_imm_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_funct_q <= '0;
        end else begin
            idex_valid_q <= 1'b1;
            idex_ctrl_q  <= ctrl;
            idex_rs1_q   <= rs1;
            idex_rs2_q   <= rs2;
            idex_rd_q    <= rd;
            idex_imm_q   <= imm;
            idex_a_q     <= rf_a;
            idex_b_q     <= rf_b;
            idex_funct_q <= {funct7, funct3};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            illegal_q <= issue && !legal;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    assign bus.idex_valid    = idex_valid_q;
    assign bus.idex_ctrl     = idex_ctrl_q;
    assign bus.idex_regs     = {idex_rs1_q, idex_rs2_q, idex_rd_q};
    assign bus.idex_imm      = idex_imm_q;
    assign bus.idex_a        = idex_a_q;
    assign bus.idex_b        = idex_b_q;
    assign bus.idex_funct    = idex_funct_q;
    assign bus.illegal_instr = illegal_q;
    assign bus.stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the ID stage rules.
`timescale 1ns/1ps
module tb_decode_stage_p;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int SW   = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decode_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .STALL_CNT_W(SW)) bus ();

    decode_stage_p #(.XLEN(XLEN), .REG_ADDR_W(RW), .STALL_CNT_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [9:0]  funct;
    } idex_t;

    idex_t       m_idex, n_idex;
    logic [31:0] m_regs [32];
    logic        m_illegal, n_illegal;
    logic [15:0] m_stalls, n_stalls;
    logic        e_stall, e_taken;
    logic [31:0] e_target;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Control words straight from the opcode table.
    function automatic void ref_decode(input logic [31:0] ins, output logic legal,
                                       output logic [7:0] ctrl, output logic use2,
                                       output logic [31:0] imm);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        legal = 1'b1; use2 = 1'b0; imm = '0; ctrl = '0;
        case (op)
            7'b0110011: begin ctrl = 8'b0100_0010; use2 = 1'b1; end
            7'b0000011: begin ctrl = 8'b1110_0100; imm = 32'($signed(ins[31:20])); end
            7'b0010011: begin ctrl = 8'b0100_0111; imm = 32'($signed(ins[31:20])); end
            7'b0100011: begin
                ctrl = 8'b0001_0100; use2 = 1'b1;
                imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                if (f3 <= 3'd1) begin
                    ctrl = 8'b0000_1001; use2 = 1'b1;
                    imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (bus.wb_we && bus.wb_rd == r) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic logic hit(input logic used, input logic [4:0] rs, input logic [4:0] p);
        return used && rs != 0 && rs == p;
    endfunction

    // Evaluate the current inputs: check combinational outputs, prepare next state.
    task automatic settle();
        logic        legal, use2, br, haz;
        logic [7:0]  ctrl;
        logic [31:0] ins, imm, a, b, ca, cb;
        logic [4:0]  rs1, rs2, rd, xr;
        #1;
        ins = bus.instruction;
        rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7]; xr = bus.exmem_rd;
        ref_decode(ins, legal, ctrl, use2, imm);
        br = legal && ctrl[3];
        a = read_reg(rs1); b = read_reg(rs2);
        ca = a; cb = b;
        haz = 1'b0;
        if (m_idex.valid && m_idex.ctrl[5] &&
            (hit(legal, rs1, m_idex.rd) || hit(use2, rs2, m_idex.rd))) haz = 1'b1;
        if (br && m_idex.valid && m_idex.ctrl[6] &&
            (hit(1'b1, rs1, m_idex.rd) || hit(1'b1, rs2, m_idex.rd))) haz = 1'b1;
        if (br && bus.exmem_mem_read && (hit(1'b1, rs1, xr) || hit(1'b1, rs2, xr))) haz = 1'b1;
        if (br && bus.exmem_reg_write && !bus.exmem_mem_read) begin
`ifdef DECODE_BRANCH_BYPASS_EN
            if (hit(1'b1, rs1, xr)) ca = bus.exmem_alu_result;
            if (hit(1'b1, rs2, xr)) cb = bus.exmem_alu_result;
`else
            if (hit(1'b1, rs1, xr) || hit(1'b1, rs2, xr)) haz = 1'b1;
`endif
        end
        e_stall  = !reset && bus.if_id_valid && haz;
        e_taken  = !reset && bus.if_id_valid && br && !haz &&
                   ((ins[14:12] == 3'd0) ? (ca == cb) : (ca != cb));
        e_target = bus.pc + imm;
        check("pc_enable", bus.pc_enable, !e_stall);
        check("if_id_enable", bus.if_id_enable, !e_stall);
        check("branch_taken", bus.branch_taken, e_taken);
        check("if_flush", bus.if_flush, e_taken);
        if (e_taken) check("branch_target", bus.branch_target, e_target);
        if (reset) begin
            n_idex = '0; n_illegal = 1'b0; n_stalls = '0;
        end else begin
            n_idex = (bus.if_id_valid && !haz) ?
                     {1'b1, ctrl, rs1, rs2, rd, imm, a, b, ins[31:25], ins[14:12]} : '0;
            n_illegal = bus.if_id_valid && !haz && !legal;
            n_stalls  = (e_stall && m_stalls != 16'hFFFF) ? m_stalls + 16'd1 : m_stalls;
        end
    endtask

    // Clock edge: commit model state and check registered outputs.
    task automatic clk();
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rst;
        we = bus.wb_we; wr = bus.wb_rd; wd = bus.wb_data; rst = reset;
        @(posedge clock);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else if (we && wr != 0) begin
            m_regs[wr] = wd;
        end
        m_idex = n_idex; m_illegal = n_illegal; m_stalls = n_stalls;
        check("idex_valid", bus.idex_valid, m_idex.valid);
        check("idex_ctrl", bus.idex_ctrl, m_idex.ctrl);
        if (m_idex.valid) begin
            check("idex_regs", bus.idex_regs, {m_idex.rs1, m_idex.rs2, m_idex.rd});
            check("idex_imm", bus.idex_imm, m_idex.imm);
            check("idex_a", bus.idex_a, m_idex.a);
            check("idex_b", bus.idex_b, m_idex.b);
            check("idex_funct", bus.idex_funct, m_idex.funct);
        end
        check("illegal_instr", bus.illegal_instr, m_illegal);
        check("stall_cycles", bus.stall_cycles, m_stalls);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1:    return {7'($urandom), rs2, rs1, f3, rd, 7'b0110011};
            2:       return enc_i(7'b0000011, 12'($urandom), rs1, 3'd2, rd);
            3:       return enc_i(7'b0010011, 12'($urandom), rs1, f3, rd);
            4:       return {7'($urandom), rs2, rs1, 3'd2, 5'($urandom), 7'b0100011};
            5, 6, 7: return enc_b(13'($urandom), rs2, rs1, 3'($urandom_range(0, 1)));
            8:       return enc_b(13'($urandom), rs2, rs1, f3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic hold;
        m_idex = '0; m_illegal = 1'b0; m_stalls = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        reset = 1'b1;
        bus.if_id_valid = 1'b0; bus.instruction = '0; bus.pc = '0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.exmem_rd = '0; bus.exmem_reg_write = 1'b0; bus.exmem_mem_read = 1'b0;
        bus.exmem_alu_result = '0;

        // Reset state
        settle(); check("reset_pc_enable", bus.pc_enable, 1'b1); clk();
        settle(); clk();
        check("reset_idex_valid", bus.idex_valid, 1'b0);
        check("reset_stall_cycles", bus.stall_cycles, 16'd0);
        reset = 1'b0;

        // add x3,x1,x2 with x1 written earlier and x2 written through this cycle
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        settle(); clk();
        bus.if_id_valid = 1'b1; bus.instruction = enc_r(5'd2, 5'd1, 5'd3);
        bus.wb_rd = 5'd2; bus.wb_data = 32'd7;
        settle(); clk();
        check("add_idex_a", bus.idex_a, 32'd5);
        check("add_idex_b", bus.idex_b, 32'd7);
        check("add_idex_ctrl", bus.idex_ctrl, 8'b01000010);
        check("add_idex_valid", bus.idex_valid, 1'b1);
        bus.wb_we = 1'b0;

        // load-use: lw x5 then add x6,x5,x1
        bus.instruction = enc_i(7'b0000011, 12'd0, 5'd1, 3'd2, 5'd5);
        settle(); clk();
        bus.instruction = enc_r(5'd1, 5'd5, 5'd6);
        settle(); check("lu_pc_enable", bus.pc_enable, 1'b0); clk();
        check("lu_bubble", bus.idex_valid, 1'b0);
        check("lu_stall_cycles", bus.stall_cycles, 16'd1);
        settle(); check("lu_release", bus.pc_enable, 1'b1); clk();
        check("lu_issue_regs", bus.idex_regs, {5'd5, 5'd1, 5'd6});

        // beq / bne x1,x1,+16 at 0x40
        bus.pc = 32'h40; bus.instruction = enc_b(13'd16, 5'd1, 5'd1, 3'd0);
        settle();
        check("beq_taken", bus.branch_taken, 1'b1);
        check("beq_flush", bus.if_flush, 1'b1);
        check("beq_target", bus.branch_target, 32'h50);
        clk();
        bus.instruction = enc_b(13'd16, 5'd1, 5'd1, 3'd1);
        settle(); check("bne_not_taken", bus.branch_taken, 1'b0); clk();

        // EX/MEM add x4 = 9, ID beq x4,x0
        bus.pc = 32'h60; bus.instruction = enc_b(13'd8, 5'd0, 5'd4, 3'd0);
        bus.exmem_rd = 5'd4; bus.exmem_reg_write = 1'b1; bus.exmem_alu_result = 32'd9;
        settle();
`ifdef DECODE_BRANCH_BYPASS_EN
        check("byp_no_stall", bus.pc_enable, 1'b1);
        check("byp_not_taken", bus.branch_taken, 1'b0);
`else
        check("exmem_alu_stall", bus.pc_enable, 1'b0);
`endif
        clk();
        bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b0;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'd9;
        settle();
        check("wb_x4_no_stall", bus.pc_enable, 1'b1);
        check("wb_x4_not_taken", bus.branch_taken, 1'b0);
        clk();
        bus.wb_we = 1'b0;

        // illegal opcode, valid then invalid
        bus.instruction = 32'h0000007F;
        settle(); clk();
        check("illegal_raised", bus.illegal_instr, 1'b1);
        check("illegal_ctrl", bus.idex_ctrl, 8'd0);
        bus.if_id_valid = 1'b0;
        settle(); clk();
        settle(); clk();
        check("illegal_invalid_quiet", bus.illegal_instr, 1'b0);

        // reset during a load-use stall
        bus.if_id_valid = 1'b1; bus.instruction = enc_i(7'b0000011, 12'd4, 5'd1, 3'd2, 5'd7);
        settle(); clk();
        bus.instruction = enc_r(5'd0, 5'd7, 5'd8);
        settle(); check("rst_stall_seen", bus.pc_enable, 1'b0);
        reset = 1'b1;
        settle();
        check("rst_pc_enable", bus.pc_enable, 1'b1);
        check("rst_branch", bus.branch_taken, 1'b0);
        clk();
        check("rst_idex_valid", bus.idex_valid, 1'b0);
        check("rst_stall_cnt", bus.stall_cycles, 16'd0);
        reset = 1'b0;

        // random traffic; IF holds the instruction while stalled
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                bus.if_id_valid = ($urandom_range(0, 7) != 0);
                bus.instruction = rand_instr();
                bus.pc = {$urandom_range(0, 32'h3FFF), 2'b00};
            end
            bus.wb_we   = $urandom_range(0, 1);
            bus.wb_rd   = 5'($urandom_range(0, 7));
            bus.wb_data = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.exmem_rd         = 5'($urandom_range(0, 7));
            bus.exmem_reg_write  = $urandom_range(0, 1);
            bus.exmem_mem_read   = ($urandom_range(0, 3) == 0);
            bus.exmem_alu_result = 32'($urandom_range(0, 3));
            reset = ($urandom_range(0, 99) == 0);
            settle();
            hold = e_stall;
            clk();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised ID stage for the 5-stage RISC-V pipeline: decodes the instruction held in IF/ID, reads a write-through register file, generates immediates and controls, and resolves `beq`/`bne` in ID. It detects load-use and branch-operand hazards, inserting bubbles and stalling IF, and owns the ID/EX pipeline register. It adds parametrised widths, `bne`, an IF/ID valid qualifier, an illegal-instruction flag, a stall counter and optional EX/MEM→ID branch forwarding.

## Interface
- XLEN, 32, datapath width (≥32)
- REG_ADDR_W, 5, register index width; 2**REG_ADDR_W registers
- STALL_CNT_W, 16, width of saturating stall counter
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_id_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  instruction from IF/ID
- pc  in  XLEN  PC of that instruction
- wb_we / wb_rd / wb_data  in  1 / REG_ADDR_W / XLEN  MEM/WB write port
- exmem_rd / exmem_reg_write / exmem_mem_read  in  REG_ADDR_W / 1 / 1  EX/MEM producer info
- exmem_alu_result  in  XLEN  EX/MEM ALU value (forwarding source)
- pc_enable, if_id_enable  out  1  0 = hold PC / IF/ID
- if_flush, branch_taken  out  1  branch taken in ID this cycle
- branch_target  out  XLEN  pc + imm
- idex_valid  out  1  ID/EX holds a real instruction
- idex_ctrl  out  8  {mem_to_reg, reg_write, mem_read, mem_write, branch, alu_src, alu_op[1:0]}
- idex_regs  out  3*REG_ADDR_W  {rs1, rs2, rd}
- idex_imm, idex_a, idex_b  out  XLEN  immediate, rs1 data, rs2 data
- idex_funct  out  10  {funct7, funct3}
- illegal_instr  out  1  registered; high one cycle after an illegal valid instruction leaves ID
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles since reset

## Operation
- Opcodes: R 0110011 (alu_op 10), load 0000011 (00, alu_src, mem_read, mem_to_reg, reg_write), I-ALU 0010011 (11, alu_src, reg_write), S 0100011 (00, alu_src, mem_write), SB 1100011 (01, branch). Any other opcode, or SB with funct3 ∉ {000,001}: controls all 0, illegal.
- Immediates sign-extended to XLEN: I, S, B (B includes bit 0 = 0). R: imm = 0.
- rs1 used by all legal opcodes; rs2 used by R, S, SB. Index 0 never creates a hazard.
- Register file: x0 reads 0; write on posedge when wb_we && wb_rd≠0; read returns wb_data when wb_we && wb_rd==rs≠0 (write-through).
- Stall (when if_id_valid) if any: (a) load-use: idex_valid && idex mem_read && idex rd matches a used rs; (b) SB operand matches idex rd with idex reg_write; (c) SB operand matches exmem_rd with exmem_mem_read; (d) see Configuration.
- On stall: pc_enable=0, if_id_enable=0, branch_taken=0, ID/EX loads a bubble (valid=0, ctrl=0); stall_cycles += 1, saturating at all-ones.
- Branch (not stalled, valid SB): beq taken if a==b, bne if a≠b → branch_taken=if_flush=1, branch_target=pc+imm.
- if_id_valid=0: no stall, no branch, bubble into ID/EX, illegal not raised.

## Timing
- Hazard/branch outputs combinational, same cycle as instruction; ID/EX registered, updates every posedge (EX never stalls).
- Stall and branch condition together: stall wins, branch re-evaluated next cycle.
- Reset: all ID/EX outputs, illegal_instr, stall_cycles, all registers = 0; while reset high: pc_enable=if_id_enable=1, branch_taken=if_flush=0. Reset mid-stall drops the stall immediately.

## Configuration
- DECODE_BRANCH_BYPASS_EN defined: SB operand matching exmem_rd with exmem_reg_write && !exmem_mem_read takes exmem_alu_result, no stall. Undefined: that case is condition (d), stall until result reaches WB (write-through).

## Structure
- decode_pkg: opcode constants, alu_op encodings, funct3 BEQ/BNE, ctrl bit indices.
- Sub-module decode_regfile (parametrised XLEN, REG_ADDR_W, write-through).

## Test plan
- Reset, then `add x3,x1,x2` with wb writing x1=5, x2=7 same cycle → idex_a=5, idex_b=7, idex_ctrl=8'b01000010, idex_valid=1.
- ID/EX holds `lw x5`; ID `add x6,x5,x1` → one stall cycle (pc_enable=0, bubble), stall_cycles=1, add issues next cycle.
- `beq x1,x1,+16` at pc=0x40, no hazard → branch_taken=if_flush=1, branch_target=0x50; `bne` same operands → not taken.
- EX/MEM `add x4` result 9, ID `beq x4,x0` → with macro: no stall, not taken; without: stalls until x4 written back.
- Opcode 0x7F valid → ctrl=0, illegal_instr=1 next cycle; same with if_id_valid=0 → illegal_instr stays 0.
- Assert reset during load-use stall → pc_enable=1 same cycle, outputs 0 next cycle.
